// File: rtl/mem_store_buffer.sv
// Store queue between the MEM stage and a slow word-addressed write bus.
// Buffers stores in a FIFO, drains them in order with req/ack, forwards to loads.
module mem_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_en,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    input  logic                     ld_en,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     ld_hit,
    output logic [DATA_W-1:0]        ld_data,
    output logic                     stall,
    output logic                     bus_req,
    output logic [ADDR_W-1:0]        bus_addr,
    output logic [DATA_W-1:0]        bus_wdata,
    input  logic                     bus_ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, REQ} state_t;

    state_t             state, stateNext;
    logic [PTR_W-1:0]   wrPtr, rdPtr;
    logic [DEPTH-1:0]   entValid;
    logic [ADDR_W-1:0]  entAddr [DEPTH];
    logic [DATA_W-1:0]  entData [DEPTH];
    logic               push, pop, loadBus;
    logic               fwdHit;
    logic [DATA_W-1:0]  fwdData;
    logic [PTR_W-1:0]   fwdIdx;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    // A pop in this cycle never frees a slot for this cycle's store.
    assign stall = st_en && full;
    assign push  = st_en && !full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        bus_req   = 1'b0;
        pop       = 1'b0;
        loadBus   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    loadBus   = 1'b1;
                    stateNext = REQ;
                end
            end
            REQ: begin
                bus_req = 1'b1;
                if (bus_ack) begin
                    pop       = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            entValid <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Clear before set; push and pop never target the same slot.
            if (pop)  entValid[rdPtr] <= 1'b0;
            if (push) entValid[wrPtr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entAddr[wrPtr] <= st_addr;
            entData[wrPtr] <= st_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else if (loadBus) begin
            bus_addr  <= entAddr[rdPtr];
            bus_wdata <= entData[rdPtr];
        end
    end

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        fwdHit  = 1'b0;
        fwdData = '0;
        fwdIdx  = rdPtr;
        for (int i = 0; i < DEPTH; i++) begin
            fwdIdx = rdPtr + PTR_W'(i);
            if (entValid[fwdIdx] && (entAddr[fwdIdx] == ld_addr)) begin
                fwdHit  = 1'b1;
                fwdData = entData[fwdIdx];
            end
        end
        ld_hit  = ld_en && fwdHit;
        ld_data = ld_hit ? fwdData : '0;
    end
endmodule
